// File: rtl/md_unit_if.sv
// E-stage HILO request/response bundle between the pipeline and md_unit.
// master is the pipeline side, slave is the multiply/divide responder.
interface md_unit_if;
   logic        en;
   logic [3:0]  hilo_type;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        start;
   logic        busy;
   logic [31:0] hilo_out;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output en, hilo_type, rs_val, rt_val,
      input  start, busy, hilo_out, hi, lo
   );

   modport slave (
      input  en, hilo_type, rs_val, rt_val,
      output start, busy, hilo_out, hi, lo
   );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at issue
// into shadow registers and committed when the busy countdown expires.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset_n,
   md_unit_if.slave  bus
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFLO  = 4'd5;
   localparam logic [3:0] OP_MFHI  = 4'd6;
   localparam logic [3:0] OP_MTLO  = 4'd7;
   localparam logic [3:0] OP_MTHI  = 4'd8;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   hi_q, lo_q;
   logic [DW-1:0]   sh_hi_q, sh_lo_q;
   logic            sh_ok_q;

   logic            is_md, is_div, start_c;
   logic [DW-1:0]   res_hi, res_lo;
   logic            res_ok;
   logic [2*DW-1:0] op_a, op_b, prod;
   logic [DW-1:0]   mag_a, mag_b, div_b, q_mag, r_mag;

   assign is_md   = (bus.hilo_type >= OP_MULT) && (bus.hilo_type <= OP_DIVU);
   assign is_div  = (bus.hilo_type == OP_DIV) || (bus.hilo_type == OP_DIVU);
   assign start_c = bus.en && is_md && (state_q == ST_IDLE);

   // Result datapath; signed divide works on magnitudes so MIN/-1 wraps cleanly.
   always_comb begin
      op_a   = {{DW{1'b0}}, bus.rs_val};
      op_b   = {{DW{1'b0}}, bus.rt_val};
      mag_a  = bus.rs_val;
      mag_b  = bus.rt_val;
      res_hi = '0;
      res_lo = '0;
      res_ok = 1'b1;
      if (bus.hilo_type == OP_MULT) begin
         op_a = {{DW{bus.rs_val[DW-1]}}, bus.rs_val};
         op_b = {{DW{bus.rt_val[DW-1]}}, bus.rt_val};
      end
      if (bus.hilo_type == OP_DIV) begin
         mag_a = bus.rs_val[DW-1] ? DW'(-bus.rs_val) : bus.rs_val;
         mag_b = bus.rt_val[DW-1] ? DW'(-bus.rt_val) : bus.rt_val;
      end
      prod  = op_a * op_b;
      div_b = (mag_b == '0) ? DW'(1) : mag_b;
      q_mag = mag_a / div_b;
      r_mag = mag_a % div_b;
      if (is_div) begin
         res_ok = (bus.rt_val != '0);
         res_lo = q_mag;
         res_hi = r_mag;
         if (bus.hilo_type == OP_DIV) begin
            if (bus.rs_val[DW-1] ^ bus.rt_val[DW-1]) res_lo = DW'(-q_mag);
            if (bus.rs_val[DW-1])                    res_hi = DW'(-r_mag);
         end
      end else begin
         res_hi = prod[2*DW-1:DW];
         res_lo = prod[DW-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sh_hi_q <= '0;
         sh_lo_q <= '0;
         sh_ok_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_c) begin
                  sh_hi_q <= res_hi;
                  sh_lo_q <= res_lo;
                  sh_ok_q <= res_ok;
                  cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  state_q <= ST_BUSY;
               end else if (bus.en && bus.hilo_type == OP_MTHI) begin
                  hi_q <= bus.rs_val;
               end else if (bus.en && bus.hilo_type == OP_MTLO) begin
                  lo_q <= bus.rs_val;
               end
            end
            ST_BUSY: begin
               if (cnt_q == CW'(1)) begin
                  if (sh_ok_q) begin
                     hi_q <= sh_hi_q;
                     lo_q <= sh_lo_q;
                  end
                  sh_ok_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
               if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // mf reads committed registers only; a same-cycle mt is not forwarded.
   always_comb begin
      bus.hilo_out = '0;
      if (bus.hilo_type == OP_MFHI) bus.hilo_out = hi_q;
      else if (bus.hilo_type == OP_MFLO) bus.hilo_out = lo_q;
   end

   assign bus.start = start_c;
   assign bus.busy  = (state_q == ST_BUSY);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed vector bench for md_unit: a table of single operations with expected
// HI/LO and busy length, plus sequences for busy-time issue and mid-op reset.
module tb_md_unit;

   logic clk = 1'b0;
   logic reset_n;
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   md_unit_if bus ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic        en;
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        exp_start;
      int          cycles;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      bus.en        = en;
      bus.hilo_type = op;
      bus.rs_val    = rs;
      bus.rt_val    = rt;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 4'd1, 32'hFFFFFFFF, 32'h00000002, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[1]  = '{1'b1, 4'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1, 5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{1'b1, 4'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{1'b1, 4'd8, 32'h00000011, 32'h0,        1'b0, 0,  32'h00000011, 32'hFFFFFFFD};
      vecs[4]  = '{1'b1, 4'd7, 32'h00000022, 32'h0,        1'b0, 0,  32'h00000011, 32'h00000022};
      vecs[5]  = '{1'b1, 4'd4, 32'h00000007, 32'h00000000, 1'b1, 10, 32'h00000011, 32'h00000022};
      vecs[6]  = '{1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000};
      vecs[7]  = '{1'b1, 4'd4, 32'h00000064, 32'h00000007, 1'b1, 10, 32'h00000002, 32'h0000000E};
      vecs[8]  = '{1'b1, 4'd3, 32'h00000007, 32'hFFFFFFFE, 1'b1, 10, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{1'b1, 4'd1, 32'h12345678, 32'h00000010, 1'b1, 5,  32'h00000001, 32'h23456780};
      vecs[10] = '{1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5,  32'hFFFFFFFE, 32'h00000001};
      vecs[11] = '{1'b1, 4'd1, 32'h80000000, 32'h80000000, 1'b1, 5,  32'h40000000, 32'h00000000};
      vecs[12] = '{1'b0, 4'd1, 32'h00000003, 32'h00000003, 1'b0, 0,  32'h40000000, 32'h00000000};
      vecs[13] = '{1'b1, 4'd0, 32'h00000005, 32'h00000005, 1'b0, 0,  32'h40000000, 32'h00000000};
      vecs[14] = '{1'b1, 4'd15, 32'h00000005, 32'h00000005, 1'b0, 0, 32'h40000000, 32'h00000000};
      vecs[15] = '{1'b0, 4'd8, 32'h0000AAAA, 32'h0,        1'b0, 0,  32'h40000000, 32'h00000000};
      vecs[16] = '{1'b1, 4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 10, 32'hFFFFFFFF, 32'h00000003};
      vecs[17] = '{1'b1, 4'd1, 32'hFFFFFFF9, 32'h00000003, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};

      reset_n = 1'b0;
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      #1;
      check("reset_busy", 32'(bus.busy), 32'h0);
      check("reset_hi", bus.hi, 32'h0);
      check("reset_lo", bus.lo, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      // Each vector issues at the current negedge, so consecutive md ops run back-to-back.
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].en, vecs[i].op, vecs[i].rs, vecs[i].rt);
         #1;
         check($sformatf("v%0d_start", i), 32'(bus.start), 32'(vecs[i].exp_start));
         @(posedge clk);
         #1;
         drive(1'b0, 4'd0, 32'h0, 32'h0);
         for (int c = 0; c < vecs[i].cycles; c++) begin
            @(negedge clk);
            check($sformatf("v%0d_busy_c%0d", i, c + 1), 32'(bus.busy), 32'h1);
         end
         @(negedge clk);
         check($sformatf("v%0d_idle", i), 32'(bus.busy), 32'h0);
         check($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
         check($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
         drive(1'b1, 4'd6, 32'h0, 32'h0);
         #1;
         check($sformatf("v%0d_mfhi", i), bus.hilo_out, vecs[i].exp_hi);
         drive(1'b1, 4'd5, 32'h0, 32'h0);
         #1;
         check($sformatf("v%0d_mflo", i), bus.hilo_out, vecs[i].exp_lo);
         drive(1'b0, 4'd0, 32'h0, 32'h0);
         #1;
         check($sformatf("v%0d_nomf", i), bus.hilo_out, 32'h0);
      end

      // mthi then mfhi next cycle; then mult with mtlo and a second mult attempted while busy.
      drive(1'b1, 4'd8, 32'hDEADBEEF, 32'h0);
      @(posedge clk);
      #1;
      drive(1'b1, 4'd6, 32'h0, 32'h0);
      #1;
      check("mthi_mfhi", bus.hilo_out, 32'hDEADBEEF);
      drive(1'b1, 4'd1, 32'h00000003, 32'h00000004);
      #1;
      check("mul34_start", 32'(bus.start), 32'h1);
      @(posedge clk);
      #1;
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      drive(1'b1, 4'd1, 32'h00000005, 32'h00000005);
      #1;
      check("busy_md_start", 32'(bus.start), 32'h0);
      drive(1'b1, 4'd7, 32'h00000055, 32'h0);
      @(posedge clk);
      #1;
      drive(1'b1, 4'd6, 32'h0, 32'h0);
      #1;
      check("busy_mfhi_stale", bus.hilo_out, 32'hDEADBEEF);
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("mul34_busy_t5", 32'(bus.busy), 32'h1);
      check("mul34_lo_pre", bus.lo, 32'hFFFFFFEB);
      @(posedge clk);
      #1;
      check("mul34_idle", 32'(bus.busy), 32'h0);
      check("mul34_hi", bus.hi, 32'h0);
      check("mul34_lo", bus.lo, 32'h0000000C);

      // Reset in the middle of a divide discards the in-flight result.
      drive(1'b1, 4'd4, 32'h00000064, 32'h00000007);
      @(posedge clk);
      #1;
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("div_rst_busy_pre", 32'(bus.busy), 32'h1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(bus.busy), 32'h0);
      check("rst_mid_hi", bus.hi, 32'h0);
      check("rst_mid_lo", bus.lo, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      check("rst_late_busy", 32'(bus.busy), 32'h0);
      check("rst_late_hi", bus.hi, 32'h0);
      check("rst_late_lo", bus.lo, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
